// File: rtl/parking_space_allocator.sv
// Occupancy manager for an 8-space lot: allocates the lowest free space on entry,
// releases spaces on exit and drives a shared gate for GATE_CYCLES cycles per accepted car.
module parking_space_allocator #(
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [2:0] exit_num,
  output logic       entry_ack,
  output logic       entry_reject,
  output logic [2:0] entry_number,
  output logic       exit_ack,
  output logic       exit_error,
  output logic [2:0] park_number,
  output logic       park_valid,
  output logic       gate_open,
  output logic [7:0] occupancy,
  output logic [3:0] free_count,
  output logic       full,
  output logic       empty
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GATE = 1'b1;

  // Loaded on acceptance so the gate stays high for exactly GATE_CYCLES cycles.
  localparam logic [3:0] GATE_LOAD = 4'(GATE_CYCLES - 1);

  logic [0:0] state;
  logic [3:0] timer;
  logic       exit_hit;
  logic [2:0] free_idx;

  // Space n lives at bit [7-n] so the map lines up with the downstream one-hot decoder.
  assign exit_hit = occupancy[3'd7 - exit_num];

  // Walk from the highest space number down so the lowest free space wins.
  always_comb begin
    free_idx = '0;
    for (int n = 7; n >= 0; n--) begin
      if (!occupancy[7 - n]) free_idx = 3'(n);
    end
  end

  // NOTE: every register here is written with <= so all updates take effect together at the edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      occupancy    <= '0;
      free_count   <= 4'd8;
      full         <= 1'b0;
      empty        <= 1'b1;
      entry_ack    <= 1'b0;
      entry_reject <= 1'b0;
      entry_number <= '0;
      exit_ack     <= 1'b0;
      exit_error   <= 1'b0;
      park_number  <= '0;
      park_valid   <= 1'b0;
      gate_open    <= 1'b0;
    end else begin
      entry_ack    <= 1'b0;
      entry_reject <= 1'b0;
      exit_ack     <= 1'b0;
      exit_error   <= 1'b0;
      park_valid   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (exit_req) begin
            if (exit_hit) begin
              occupancy[3'd7 - exit_num] <= 1'b0;
              free_count  <= free_count + 4'd1;
              full        <= 1'b0;
              empty       <= (free_count == 4'd7);
              park_number <= exit_num;
              exit_ack    <= 1'b1;
              park_valid  <= 1'b1;
              gate_open   <= 1'b1;
              timer       <= GATE_LOAD;
              state       <= ST_GATE;
            end else begin
              exit_error <= 1'b1;
            end
          end else if (entry_req) begin
            if (!full) begin
              occupancy[3'd7 - free_idx] <= 1'b1;
              free_count   <= free_count - 4'd1;
              full         <= (free_count == 4'd1);
              empty        <= 1'b0;
              entry_number <= free_idx;
              entry_ack    <= 1'b1;
              gate_open    <= 1'b1;
              timer        <= GATE_LOAD;
              state        <= ST_GATE;
            end else begin
              entry_reject <= 1'b1;
            end
          end
        end

        ST_GATE: begin
          // Requests are ignored here; requesters keep them asserted until served.
          if (timer == 4'd0) begin
            gate_open <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            timer <= timer - 4'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_space_allocator.sv
// Scoreboard bench for parking_space_allocator: a reference occupancy model pushes expected
// results as requests are driven; each handshake pulse pops and compares one entry.
module tb_parking_space_allocator;

  logic       clk = 1'b0;
  logic       nrst;
  logic       entry_req, exit_req;
  logic [2:0] exit_num;
  logic       entry_ack, entry_reject, exit_ack, exit_error, park_valid, gate_open;
  logic [2:0] entry_number, park_number;
  logic [7:0] occupancy;
  logic [3:0] free_count;
  logic       full, empty;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  parking_space_allocator #(.GATE_CYCLES(4)) dut (
    .clk(clk), .nrst(nrst),
    .entry_req(entry_req), .exit_req(exit_req), .exit_num(exit_num),
    .entry_ack(entry_ack), .entry_reject(entry_reject), .entry_number(entry_number),
    .exit_ack(exit_ack), .exit_error(exit_error),
    .park_number(park_number), .park_valid(park_valid),
    .gate_open(gate_open), .occupancy(occupancy), .free_count(free_count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pulses = {entry_ack, entry_reject, exit_ack, exit_error, park_valid}
  typedef struct packed {
    logic [4:0] pulses;
    logic [2:0] entry_num;
    logic [2:0] park_num;
    logic [7:0] occ;
    logic [3:0] free;
    logic       full;
    logic       empty;
  } obs_t;

  localparam obs_t RESET_OBS = '{pulses: 5'b0, entry_num: 3'd0, park_num: 3'd0,
                                 occ: 8'h00, free: 4'd8, full: 1'b0, empty: 1'b1};

  logic [7:0] m_occ;
  logic [2:0] m_entry, m_park;
  obs_t       sb_q[$];

  function automatic obs_t observe();
    obs_t o;
    o.pulses    = {entry_ack, entry_reject, exit_ack, exit_error, park_valid};
    o.entry_num = entry_number;
    o.park_num  = park_number;
    o.occ       = occupancy;
    o.free      = free_count;
    o.full      = full;
    o.empty     = empty;
    return o;
  endfunction

  task automatic model_reset();
    m_occ   = 8'h00;
    m_entry = 3'd0;
    m_park  = 3'd0;
    sb_q.delete();
  endtask

  // Reference behaviour for one request evaluated in IDLE.
  task automatic predict(input bit e, input bit x, input logic [2:0] num);
    obs_t t;
    t.pulses = 5'b0;
    if (x) begin
      if (m_occ[7 - num]) begin
        m_occ[7 - num] = 1'b0;
        m_park   = num;
        t.pulses = 5'b00101;
      end else begin
        t.pulses = 5'b00010;
      end
    end else if (e) begin
      if (m_occ != 8'hFF) begin
        for (int n = 7; n >= 0; n--) if (!m_occ[7 - n]) m_entry = 3'(n);
        m_occ[7 - m_entry] = 1'b1;
        t.pulses = 5'b10000;
      end else begin
        t.pulses = 5'b01000;
      end
    end
    t.entry_num = m_entry;
    t.park_num  = m_park;
    t.occ       = m_occ;
    t.free      = 4'(8 - $countones(m_occ));
    t.full      = (m_occ == 8'hFF);
    t.empty     = (m_occ == 8'h00);
    sb_q.push_back(t);
  endtask

  task automatic wait_pulse(output bit to);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (entry_ack || entry_reject || exit_ack || exit_error) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_gate_closed(output bit to, output int len);
    to  = 1'b1;
    len = 0;
    for (int i = 0; i < 20; i++) begin
      if (!gate_open) begin
        to = 1'b0;
        break;
      end
      len++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_num = 3'd0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (observe() !== RESET_OBS || gate_open !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got %h gate=%b want %h gate=0", observe(), gate_open, RESET_OBS);
    end
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (observe() !== RESET_OBS || gate_open !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got %h gate=%b want %h gate=0", observe(), gate_open, RESET_OBS);
    end
  endtask

  task automatic test_back_to_back();
    bit to; int last, len; obs_t exp, obs;
    last = 0;
    entry_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      predict(1'b1, 1'b0, 3'd0);
      wait_pulse(to);
      exp = sb_q.pop_front();
      obs = observe();
      checks++;
      if (to || obs !== exp) begin
        failures++;
        $display("FAIL b2b_entry%0d: got %h timeout=%0d want %h", i, obs, to, exp);
      end
      if (i > 0) begin
        checks++;
        if (cyc - last !== 5) begin
          failures++;
          $display("FAIL b2b_spacing%0d: got %0d want 5", i, cyc - last);
        end
      end
      last = cyc;
    end
    entry_req = 1'b0;
    wait_gate_closed(to, len);
    checks++;
    if (to || len !== 4) begin
      failures++;
      $display("FAIL b2b_gate_len: got %0d timeout=%0d want 4", len, to);
    end
  endtask

  task automatic test_full_reject();
    bit to; int last; obs_t exp, obs;
    last = 0;
    entry_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      predict(1'b1, 1'b0, 3'd0);
      wait_pulse(to);
      exp = sb_q.pop_front();
      obs = observe();
      checks++;
      if (to || obs !== exp || gate_open !== 1'b0) begin
        failures++;
        $display("FAIL full_reject%0d: got %h gate=%b timeout=%0d want %h gate=0", i, obs, gate_open, to, exp);
      end
      if (i > 0) begin
        checks++;
        if (cyc - last !== 1) begin
          failures++;
          $display("FAIL reject_rate%0d: got %0d want 1", i, cyc - last);
        end
      end
      last = cyc;
    end
    entry_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_exit_reuse();
    bit to; int len; obs_t exp, obs;
    exit_req = 1'b1; exit_num = 3'd3;
    predict(1'b0, 1'b1, 3'd3);
    wait_pulse(to);
    exp = sb_q.pop_front();
    obs = observe();
    checks++;
    if (to || obs !== exp || obs.occ !== 8'hEF || obs.free !== 4'd1) begin
      failures++;
      $display("FAIL exit3: got %h timeout=%0d want %h", obs, to, exp);
    end
    exit_req = 1'b0;
    wait_gate_closed(to, len);
    entry_req = 1'b1;
    predict(1'b1, 1'b0, 3'd0);
    wait_pulse(to);
    exp = sb_q.pop_front();
    obs = observe();
    checks++;
    if (to || obs !== exp || obs.entry_num !== 3'd3) begin
      failures++;
      $display("FAIL reuse3: got %h timeout=%0d want %h", obs, to, exp);
    end
    entry_req = 1'b0;
    wait_gate_closed(to, len);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL reuse_gate: gate still open after bound");
    end
  endtask

  task automatic test_exit_error();
    bit to; int len; obs_t exp, obs;
    for (int s = 1; s < 8; s++) begin
      exit_req = 1'b1; exit_num = 3'(s);
      predict(1'b0, 1'b1, 3'(s));
      wait_pulse(to);
      exp = sb_q.pop_front();
      obs = observe();
      checks++;
      if (to || obs !== exp) begin
        failures++;
        $display("FAIL drain_exit%0d: got %h timeout=%0d want %h", s, obs, to, exp);
      end
      exit_req = 1'b0;
      wait_gate_closed(to, len);
    end
    exit_req = 1'b1; exit_num = 3'd5;
    predict(1'b0, 1'b1, 3'd5);
    wait_pulse(to);
    exp = sb_q.pop_front();
    obs = observe();
    checks++;
    if (to || obs !== exp || gate_open !== 1'b0 || obs.occ !== 8'h80) begin
      failures++;
      $display("FAIL exit_error: got %h gate=%b timeout=%0d want %h gate=0", obs, gate_open, to, exp);
    end
    exit_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({entry_ack, entry_reject, exit_ack, exit_error, gate_open} !== 5'b0 || occupancy !== 8'h80) begin
      failures++;
      $display("FAIL exit_error_single: pulses/gate=%b occ=%h want 00000 occ=80",
               {entry_ack, entry_reject, exit_ack, exit_error, gate_open}, occupancy);
    end
  endtask

  task automatic test_simultaneous();
    bit to; int first, len; obs_t exp, obs;
    entry_req = 1'b1; exit_req = 1'b1; exit_num = 3'd0;
    predict(1'b1, 1'b1, 3'd0);
    wait_pulse(to);
    exp = sb_q.pop_front();
    obs = observe();
    checks++;
    if (to || obs !== exp || obs.empty !== 1'b1) begin
      failures++;
      $display("FAIL simul_exit_first: got %h timeout=%0d want %h", obs, to, exp);
    end
    first = cyc;
    exit_req = 1'b0;
    predict(1'b1, 1'b0, 3'd0);
    wait_pulse(to);
    exp = sb_q.pop_front();
    obs = observe();
    checks++;
    if (to || obs !== exp || obs.entry_num !== 3'd0 || cyc - first !== 5) begin
      failures++;
      $display("FAIL simul_entry_after: got %h after %0d cycles timeout=%0d want %h after 5", obs, cyc - first, to, exp);
    end
    entry_req = 1'b0;
    wait_gate_closed(to, len);
  endtask

  task automatic test_reset_mid_gate();
    bit to; obs_t exp, obs;
    entry_req = 1'b1;
    predict(1'b1, 1'b0, 3'd0);
    wait_pulse(to);
    exp = sb_q.pop_front();
    obs = observe();
    checks++;
    if (to || obs !== exp) begin
      failures++;
      $display("FAIL pre_reset_entry: got %h timeout=%0d want %h", obs, to, exp);
    end
    entry_req = 1'b0;
    @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (observe() !== RESET_OBS || gate_open !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_gate: got %h gate=%b want %h gate=0", observe(), gate_open, RESET_OBS);
    end
    @(negedge clk);
    nrst = 1'b1;
    entry_req = 1'b1;
    predict(1'b1, 1'b0, 3'd0);
    wait_pulse(to);
    exp = sb_q.pop_front();
    obs = observe();
    checks++;
    if (to || obs !== exp || obs.occ !== 8'h80) begin
      failures++;
      $display("FAIL post_reset_entry: got %h timeout=%0d want %h", obs, to, exp);
    end
    entry_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full_reject();
    test_exit_reuse();
    test_exit_error();
    test_simultaneous();
    test_reset_mid_gate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parking_space_allocator.md
Name: parking_space_allocator

Overview:
Sequential occupancy manager for the 8-space lot. Accepts car entry and exit requests through a req/ack handshake and allocates the lowest-numbered free space on entry. Releases a space on exit and runs a shared gate timer. Its registered park_number/park_valid outputs feed the downstream 3-to-8 exit one-hot location decoder directly.

Parameters:
GATE_CYCLES, 4, cycles gate_open stays high per accepted entry/exit; legal range 1..15.

Ports:
clk  input  1  system clock, rising-edge active
nrst  input  1  reset, asynchronous, active-low
entry_req  input  1  car waiting at entry; level, held until entry_ack or entry_reject
exit_req  input  1  car waiting at exit; level, held until exit_ack or exit_error
exit_num  input  3  space number of exiting car; stable while exit_req=1
entry_ack  output  1  one-cycle pulse: entry accepted
entry_reject  output  1  one-cycle pulse: entry refused, lot full
entry_number  output  3  space assigned on last entry_ack; holds until next ack
exit_ack  output  1  one-cycle pulse: exit accepted
exit_error  output  1  one-cycle pulse: exit_num space not occupied
park_number  output  3  space released on last exit_ack, to downstream decoder
park_valid  output  1  one-cycle pulse coincident with exit_ack
gate_open  output  1  gate actuator
occupancy  output  8  occupied map; space n is bit [7-n], matching the decoder one-hot order (space 0 = bit 7)
free_count  output  4  number of free spaces, 0..8
full  output  1  free_count==0
empty  output  1  free_count==8

Behaviour:
- Reset (nrst=0, async): state=IDLE, occupancy=8'h00, free_count=8, empty=1, full=0. All pulses=0, gate_open=0, entry_number=0, park_number=0, timer=0. Reset mid-gate aborts the gate and clears occupancy.
- States: IDLE, GATE. Requests are sampled only in IDLE; in GATE they are ignored and must be held by the requester.
- IDLE, exit_req=1 (priority over entry_req when both are high):
  - If occupancy[7-exit_num]=1: at the next edge clear that bit, free_count+1, exit_ack=1, park_valid=1, park_number=exit_num, gate_open=1, timer=GATE_CYCLES-1, state->GATE.
  - Otherwise: exit_error=1 for one cycle, stay in IDLE, no other change.
- IDLE, entry_req=1, exit_req=0:
  - If not full: at the next edge set the bit of the lowest-numbered free space n (priority from bit 7 down), entry_number=n, free_count-1, entry_ack=1, gate_open=1, timer=GATE_CYCLES-1, state->GATE.
  - If full: entry_reject=1 for one cycle, stay in IDLE.
- GATE: timer decrements each cycle. When timer==0, at the next edge gate_open=0 and state->IDLE. gate_open is therefore high exactly GATE_CYCLES cycles.
- Latency: a request sampled at edge k produces its ack/reject/error pulse during cycle k+1. The earliest next acceptance is GATE_CYCLES+1 cycles after an ack. A request still high in IDLE after a reject or error is re-evaluated as a new request, so reject repeats every cycle while the lot stays full.
- full, empty and free_count are derived from registered occupancy and are valid the cycle after the update. free_count always equals the number of zeros in occupancy.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then 8 back-to-back entries, GATE_CYCLES=4 -> entry_number 0,1,...,7; occupancy 80,C0,...,FF; full=1 after the 8th; acks spaced 5 cycles apart.
- Full lot, entry_req held -> entry_reject pulses every cycle, occupancy stays FF, gate_open=0.
- occupancy=FF, exit_req with exit_num=3 -> exit_ack+park_valid, park_number=3, occupancy=EF, free_count=1; next entry gets entry_number=3.
- occupancy=80, exit_num=5 -> exit_error single pulse, occupancy unchanged, no gate_open.
- entry_req and exit_req (exit_num=0) asserted together with occupancy=80 -> exit served first (occupancy=00, empty=1); entry then served after the gate closes, entry_number=0.
- nrst pulled low during GATE at timer=2 -> gate_open drops immediately (async), occupancy=00, free_count=8; the next request is served normally.
